// File: rtl/sram_pkg.sv
// sram_pkg: FSM state encoding, default timing constants and sizing helper for sram_ctrl.
package sram_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_t;
  localparam int DEF_ADDR_W      = 20;
  localparam int DEF_RD_CYCLES   = 2;
  localparam int DEF_WR_CYCLES   = 2;
  localparam int DEF_TURN_CYCLES = 1;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/sram_req_slot.sv
// sram_req_slot: one-deep request register {rw, addr, data}; a load in the same cycle as a take refills it.
module sram_req_slot #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_take,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  output logic              o_valid,
  output logic              o_rw,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_data
);
  logic              r_valid;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= i_load | (r_valid & ~i_take);
      if (i_load) begin
        r_rw   <= i_rw;
        r_addr <= i_addr;
        r_data <= i_data;
      end
    end
  end
  assign o_valid = r_valid;
  assign o_rw    = r_rw;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: turns single-cycle CPU mem strobes into timed async-SRAM cycles with registered pins.
// Define SRAM_CTRL_PENDING_EN to queue one strobe arriving while busy instead of dropping it.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int RD_CYCLES   = DEF_RD_CYCLES,
  parameter int WR_CYCLES   = DEF_WR_CYCLES,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [7:0]        iData,
  input  logic              iRd,
  input  logic              iWr,
  input  logic              iSel,
  input  logic              iOvrClr,
  output logic [7:0]        oData,
  output logic              oValid,
  output logic              oBusy,
  output logic              oOverrun,
  output logic [ADDR_W-1:0] oSramA,
  output logic [7:0]        oSramDout,
  input  logic [7:0]        iSramDin,
  output logic              oSramDir,
  output logic              oSramOe,
  output logic              oSramWe,
  output logic              oSramCe1,
  output logic              oSramCe2
);
  localparam int CW = $clog2(max3(RD_CYCLES, WR_CYCLES, TURN_CYCLES)) + 1;
  localparam logic [CW-1:0] RD_LD = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LD = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] TN_LD = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  state_t            r_state, w_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              w_acc, w_coll, w_idle, w_drop, w_start, w_rd_done;
  logic              w_pend_v, w_pend_rw;
  logic [ADDR_W-1:0] w_pend_addr;
  logic [7:0]        w_pend_data;
  logic              w_st_rw;
  logic [ADDR_W-1:0] w_st_addr;
  logic [7:0]        w_st_data;
  logic              r_oe, r_we, r_dir, r_ce, r_valid, r_ovr;
  logic [ADDR_W-1:0] r_a;
  logic [7:0]        r_dout, r_data;
  assign w_acc  = (iRd | iWr) & iSel;
  assign w_coll = iRd & iWr & iSel;
  assign w_idle = (r_state == IDLE);
`ifdef SRAM_CTRL_PENDING_EN
  logic w_load;
  assign w_drop = w_acc & ~w_idle & w_pend_v;
  // In IDLE a valid slot is drained this cycle, so a new strobe may refill it
  assign w_load = w_acc & (w_idle ? w_pend_v : ~w_pend_v);
  sram_req_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk    (iClk),
    .rst    (iReset),
    .i_load (w_load),
    .i_take (w_idle & w_pend_v),
    .i_rw   (iWr),
    .i_addr (iAddr),
    .i_data (iData),
    .o_valid(w_pend_v),
    .o_rw   (w_pend_rw),
    .o_addr (w_pend_addr),
    .o_data (w_pend_data)
  );
`else
  assign w_drop      = w_acc & ~w_idle;
  assign w_pend_v    = 1'b0;
  assign w_pend_rw   = 1'b0;
  assign w_pend_addr = '0;
  assign w_pend_data = '0;
`endif
  assign w_start   = w_idle & (w_pend_v | w_acc);
  assign w_st_rw   = w_pend_v ? w_pend_rw : iWr;
  assign w_st_addr = w_pend_v ? w_pend_addr : iAddr;
  assign w_st_data = w_pend_v ? w_pend_data : iData;
  assign w_rd_done = (r_state == RD) & (r_cnt == '0);
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
    unique case (r_state)
      IDLE: if (w_start) begin
        w_nxt     = w_st_rw ? WR : RD;
        w_cnt_nxt = w_st_rw ? WR_LD : RD_LD;
      end
      RD:   if (r_cnt == '0) w_nxt = IDLE;
      WR:   if (r_cnt == '0) begin
        w_nxt     = (TURN_CYCLES > 0) ? TURN : IDLE;
        w_cnt_nxt = TN_LD;
      end
      TURN: if (r_cnt == '0) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // Pin strobes are decoded from the next state so they line up with the state they belong to
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_oe    <= 1'b1;
      r_we    <= 1'b1;
      r_dir   <= 1'b0;
      r_ce    <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_a     <= '0;
      r_dout  <= '0;
      r_data  <= '0;
    end else begin
      r_oe    <= (w_nxt != RD);
      r_we    <= (w_nxt != WR);
      r_dir   <= (w_nxt == WR) | (w_nxt == TURN);
      r_ce    <= (w_nxt != IDLE);
      r_valid <= w_rd_done;
      r_ovr   <= w_coll | w_drop | (r_ovr & ~iOvrClr);
      if (w_rd_done) r_data <= iSramDin;
      if (w_start) begin
        r_a    <= w_st_addr;
        r_dout <= w_st_data;
      end
    end
  end
  assign oData     = r_data;
  assign oValid    = r_valid;
  assign oBusy     = ~w_idle | w_pend_v;
  assign oOverrun  = r_ovr;
  assign oSramA    = r_a;
  assign oSramDout = r_dout;
  assign oSramDir  = r_dir;
  assign oSramOe   = r_oe;
  assign oSramWe   = r_we;
  assign oSramCe1  = ~r_ce;
  assign oSramCe2  = r_ce;
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Downstream consumer of the internal CPU bus strobes from the V20 bus bridge. Turns single-cycle mem read/write strobes into timed async-SRAM cycles.
- Replaces the ad-hoc one-cycle SRAM sequencing in the top level with a parameterised FSM. Provides a registered read-data latch, busy/valid handshake and an overrun flag.
- Sits between the address decoder (selRam) and the SRAM pins. Tristate of the data bus stays in the top level, driven by oSramDir.

Parameters:
- ADDR_W, 20, CPU/SRAM address width.
- RD_CYCLES, 2, cycles oSramOe held low before data is sampled (min 1).
- WR_CYCLES, 2, cycles oSramWe held low (min 1).
- TURN_CYCLES, 1, cycles data stays driven after WE rises (min 0).

Ports:
- iClk  in  1  system clock (10 MHz domain)
- iReset  in  1  asynchronous reset, active-high
- iAddr  in  ADDR_W  CPU address, valid with strobe
- iData  in  8  CPU write data, valid with iWr
- iRd  in  1  mem read strobe, single cycle
- iWr  in  1  mem write strobe, single cycle
- iSel  in  1  address decode hit (RAM region); strobes ignored when 0
- iOvrClr  in  1  clears oOverrun
- oData  out  8  latched read data
- oValid  out  1  one-cycle pulse, oData updated
- oBusy  out  1  transaction in progress or pending
- oOverrun  out  1  sticky, a strobe was dropped
- oSramA  out  ADDR_W  registered SRAM address
- oSramDout  out  8  registered write data
- iSramDin  in  8  SRAM read data from pins
- oSramDir  out  1  1 = fpga->sram, 0 = sram->fpga
- oSramOe  out  1  active low
- oSramWe  out  1  active low
- oSramCe1  out  1  active low
- oSramCe2  out  1  active high

Behaviour:
- All SRAM outputs are registered.
- Reset values (async): state IDLE, oSramOe=1, oSramWe=1, oSramDir=0, oSramCe1=1, oSramCe2=0, oSramA=0, oSramDout=0, oData=0, oValid=0, oOverrun=0, pending cleared.
- Reset mid-transaction aborts immediately. No completion pulse follows.
- Accept condition: (iRd|iWr) & iSel.
- iRd&iWr in the same cycle: the write is accepted, the read is dropped, and oOverrun is set.
- States: IDLE, RD, WR, TURN.
  - IDLE: OE=1, WE=1, DIR=0, CE inactive.
- Read (strobe at cycle 0):
  - Cycle 0 latches the address and moves to RD.
  - Cycles 1..RD_CYCLES: OE=0, CE active.
  - At the end of cycle RD_CYCLES, iSramDin is captured into oData. oValid=1 during cycle RD_CYCLES+1, and the FSM returns to IDLE.
- Write:
  - Cycle 0 latches the address and data, then WR.
  - Cycles 1..WR_CYCLES: DIR=1, WE=0, CE active.
  - TURN for TURN_CYCLES: WE=1, DIR=1, CE active.
  - Then IDLE with DIR=0. When TURN_CYCLES=0, WR goes straight to IDLE.
- oSramA and oSramDout stay stable for the whole transaction.
- oBusy = (state != IDLE) | pending_valid.
- A strobe arriving while busy follows the optional-feature rules.
- oOverrun: set by any dropped strobe. Cleared by iOvrClr. If set and clear coincide, set wins.
- Internal down-counter width is clog2 of the max cycle parameter plus 1. No wrap: the counter is loaded on state entry and exits at 0.

Optional Feature:
- Macro: SRAM_CTRL_PENDING_EN.
- Defined:
  - A one-deep pending slot holds {rw, addr, data}.
  - A strobe accepted while busy fills the slot if it is empty; otherwise it is dropped and oOverrun is set.
  - In IDLE, a valid pending entry is started, with priority over a new strobe. A new strobe in that same cycle refills the freed slot.
- Undefined:
  - Any accepted strobe while state != IDLE is dropped and oOverrun is set.
  - pending_valid is constant 0.

Decomposition:
- Package sram_pkg: state encoding localparams (IDLE/RD/WR/TURN) and default timing constants.
- Sub-module sram_req_slot: the one-deep request register with valid/load/take. Instantiated only under SRAM_CTRL_PENDING_EN.

Test Plan (defaults: RD_CYCLES=2, WR_CYCLES=2, TURN_CYCLES=1):
- Reset: assert iReset during WR (WE=0) -> same cycle WE=1, OE=1, DIR=0, oBusy=0, oData=00, CE inactive.
- Read: iAddr=12345h, iRd pulse at cycle 0, model returns A5h -> oSramA=12345h, OE low cycles 1-2, oValid high only at cycle 3 with oData=A5h.
- Write: iAddr=9FFFFh, iData=3Ch -> WE low cycles 1-2, DIR=1 cycles 1-3, DIR=0 at cycle 4. A readback of 9FFFFh returns 3Ch.
- Back-to-back: iWr (00010h, 55h) at cycle 0, iRd 00010h at cycle 1.
  - With EN: the read starts after the write and returns 55h, one oValid, oOverrun=0.
  - Without EN: the read is dropped, oOverrun=1.
- Decode miss: iRd with iSel=0 (iAddr FE000h) -> no OE/CE activity, oBusy stays 0, no oValid.
- Collision: iRd&iWr together (00020h, 77h) -> the write is performed, oOverrun=1. An iOvrClr pulse clears it. A simultaneous new drop plus clear leaves it at 1.
